// File: rtl/adc_in_pkg.sv
// Shared fixed-point definitions for the converter data paths.
// Q16.48 is the reference format: 16 integer bits (sign included) and 48
// fraction bits in a 64-bit two's-complement word.
//   FP_WIDTH_Q / INT_WIDTH_Q : reference word and integer widths
//   K_MAG / K_SHIFT          : code-to-volts scale K = -K_MAG * 2^-K_SHIFT
//   K_Q16_48                 : K encoded in Q16.48 (-5 * 2^-12)
//   SAT_POS/NEG_Q16_48       : Q16.48 clamp values
//   AVG_LOG2_W               : width of the averaging exponent control
package adc_in_pkg;

  localparam int FP_WIDTH_Q  = 64;
  localparam int INT_WIDTH_Q = 16;
  localparam int AVG_LOG2_W  = 4;

  localparam int K_MAG   = 5;
  localparam int K_SHIFT = 12;

  localparam logic [63:0] K_Q16_48       = 64'hFFFF_FFB0_0000_0000;
  localparam logic [63:0] SAT_POS_Q16_48 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG_Q16_48 = 64'h8000_0000_0000_0000;

  // Per-stage control carried alongside the data word.
  typedef struct packed {
    logic valid;
    logic sat;
  } stage_flags_t;

endpackage

// File: rtl/adc_in_if.sv
// Sample input / voltage output bundle of adc_in.
// Handshake: valid-only, no backpressure. ADC_VALID marks a cycle whose
// ADC_CODE_IN is consumed at the next rising edge; VOLTAGE_VALID is a one-cycle
// strobe marking a new VOLTAGE_OUT/VOLTAGE_SAT pair, which then hold until the
// next strobe. The consumer must accept every strobe.
//   master : drives samples and calibration, observes results (bench side)
//   slave  : the converter itself
interface adc_in_if
  import adc_in_pkg::*;
#(
  parameter int FP_WIDTH  = FP_WIDTH_Q,
  parameter int ADC_WIDTH = 14
) ();

  logic [ADC_WIDTH-1:0]  ADC_CODE_IN;
  logic                  ADC_VALID;
  logic [AVG_LOG2_W-1:0] AVG_LOG2;
  logic [FP_WIDTH-1:0]   ADC_CAL_GAIN;
  logic [FP_WIDTH-1:0]   ADC_CAL_OFFSET;
  logic [FP_WIDTH-1:0]   VOLTAGE_OUT;
  logic                  VOLTAGE_VALID;
  logic                  VOLTAGE_SAT;

  modport master (
    output ADC_CODE_IN, ADC_VALID, AVG_LOG2, ADC_CAL_GAIN, ADC_CAL_OFFSET,
    input  VOLTAGE_OUT, VOLTAGE_VALID, VOLTAGE_SAT
  );

  modport slave (
    input  ADC_CODE_IN, ADC_VALID, AVG_LOG2, ADC_CAL_GAIN, ADC_CAL_OFFSET,
    output VOLTAGE_OUT, VOLTAGE_VALID, VOLTAGE_SAT
  );

endinterface

// File: rtl/adc_in_fp_sat_mult.sv
// fp_sat_mult: combinational signed fixed-point multiply with saturation.
//   a, b : signed operands in the same fixed-point format
//   res  : product realigned to the operand format, clamped on overflow
//   sat  : high when res was clamped
module fp_sat_mult
  import adc_in_pkg::*;
#(
  parameter int FP_WIDTH  = FP_WIDTH_Q,
  parameter int INT_WIDTH = INT_WIDTH_Q
) (
  input  logic signed [FP_WIDTH-1:0] a,
  input  logic signed [FP_WIDTH-1:0] b,
  output logic        [FP_WIDTH-1:0] res,
  output logic                       sat
);

  localparam int FRAC_W = FP_WIDTH - INT_WIDTH;
  localparam int PW     = 2 * FP_WIDTH;
  localparam bit IS_Q   = (FP_WIDTH == FP_WIDTH_Q);
  localparam logic [FP_WIDTH-1:0] SAT_POS =
    IS_Q ? FP_WIDTH'(SAT_POS_Q16_48) : {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] SAT_NEG =
    IS_Q ? FP_WIDTH'(SAT_NEG_Q16_48) : {1'b1, {(FP_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_shr;
  logic [FP_WIDTH:0]    hi;

  always_comb begin
    prod     = PW'(a) * PW'(b);
    // Shifting by the fraction width puts the kept field at [FP_WIDTH-1:0];
    // everything from its sign bit upward must be one repeated bit.
    prod_shr = prod >>> FRAC_W;
    hi       = prod_shr[PW-1:FP_WIDTH-1];
    sat      = !((&hi) || !(|hi));
    if (sat) begin
      res = prod[PW-1] ? SAT_NEG : SAT_POS;
    end else begin
      res = prod_shr[FP_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/adc_in.sv
// adc_in: averages raw ADC codes over 2^AVG_LOG2 samples and converts the
// average to a calibrated voltage:
//   VOLTAGE_OUT = ((avg_code * K) + ADC_CAL_OFFSET) * ADC_CAL_GAIN
// Three registered stages: scale by K, add offset, multiply by gain.
//   CLK   : rising-edge clock
//   RST_N : synchronous active-low reset
//   bus   : adc_in_if slave (samples, calibration words, voltage result)
module adc_in
  import adc_in_pkg::*;
#(
  parameter int FP_WIDTH     = FP_WIDTH_Q,
  parameter int ADC_WIDTH    = 14,
  parameter int INT_WIDTH    = INT_WIDTH_Q,
  parameter int MAX_AVG_LOG2 = 8
) (
  input logic     CLK,
  input logic     RST_N,
  adc_in_if.slave bus
);

  localparam int FRAC_W = FP_WIDTH - INT_WIDTH;
  localparam int ACC_W  = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int CNT_W  = MAX_AVG_LOG2 + 1;
  localparam bit IS_Q   = (FP_WIDTH == FP_WIDTH_Q) && (INT_WIDTH == INT_WIDTH_Q);

  localparam logic [FP_WIDTH-1:0] K_MAG_FP = FP_WIDTH'(K_MAG) << (FRAC_W - K_SHIFT);
  localparam logic [FP_WIDTH-1:0] K_FP =
    IS_Q ? FP_WIDTH'(K_Q16_48) : (~K_MAG_FP + FP_WIDTH'(1));
  localparam logic [FP_WIDTH-1:0] SAT_POS =
    IS_Q ? FP_WIDTH'(SAT_POS_Q16_48) : {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] SAT_NEG =
    IS_Q ? FP_WIDTH'(SAT_NEG_Q16_48) : {1'b1, {(FP_WIDTH-1){1'b0}}};
  localparam logic [AVG_LOG2_W-1:0] MAX_LOG2 = AVG_LOG2_W'(MAX_AVG_LOG2);

  // ---------------- averaging window ----------------
  logic signed [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]            cnt;
  logic [AVG_LOG2_W-1:0]       cur_log2;

  logic [AVG_LOG2_W-1:0]       avg_in;
  logic [AVG_LOG2_W-1:0]       eff_log2;
  logic                        restart;
  logic signed [ADC_WIDTH-1:0] code_s;
  logic signed [ACC_W-1:0]     base_acc;
  logic [CNT_W-1:0]            base_cnt;
  logic signed [ACC_W-1:0]     sum_next;
  logic [CNT_W-1:0]            cnt_next;
  logic                        win_done;
  logic signed [ADC_WIDTH-1:0] avg_code;
  logic signed [FP_WIDTH-1:0]  avg_fp;

  always_comb begin
    avg_in   = (bus.AVG_LOG2 > MAX_LOG2) ? MAX_LOG2 : bus.AVG_LOG2;
    // An empty window takes the current exponent; a changed exponent
    // mid-window throws the partial sum away and starts over.
    restart  = (cnt == '0) || (avg_in != cur_log2);
    eff_log2 = restart ? avg_in : cur_log2;
    base_acc = restart ? '0 : acc;
    base_cnt = restart ? '0 : cnt;
    code_s   = bus.ADC_CODE_IN;
    sum_next = base_acc + ACC_W'(code_s);
    cnt_next = base_cnt + CNT_W'(1);
    win_done = bus.ADC_VALID && (cnt_next == (CNT_W'(1) << eff_log2));
    // Arithmetic shift gives floor rounding of the mean.
    avg_code = ADC_WIDTH'(sum_next >>> eff_log2);
    avg_fp   = FP_WIDTH'(avg_code) << FRAC_W;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc      <= '0;
      cnt      <= '0;
      cur_log2 <= '0;
    end else if (bus.ADC_VALID) begin
      cur_log2 <= eff_log2;
      if (win_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt_next;
      end
    end else if (restart) begin
      acc      <= '0;
      cnt      <= '0;
      cur_log2 <= avg_in;
    end
  end

  // ---------------- stage 1: avg_code * K ----------------
  logic [FP_WIDTH-1:0] mul1_res;
  logic                mul1_sat;
  logic [FP_WIDTH-1:0] s1_data;
  stage_flags_t        s1_flags;

  fp_sat_mult #(.FP_WIDTH(FP_WIDTH), .INT_WIDTH(INT_WIDTH)) u_mul_k (
    .a   (avg_fp),
    .b   (K_FP),
    .res (mul1_res),
    .sat (mul1_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_data  <= '0;
      s1_flags <= '0;
    end else begin
      s1_flags.valid <= win_done;
      s1_flags.sat   <= mul1_sat;
      if (win_done) begin
        s1_data <= mul1_res;
      end
    end
  end

  // ---------------- stage 2: + offset ----------------
  logic [FP_WIDTH:0]   add_sum;
  logic                add_sat;
  logic [FP_WIDTH-1:0] add_res;
  logic [FP_WIDTH-1:0] s2_data;
  stage_flags_t        s2_flags;

  always_comb begin
    add_sum = {s1_data[FP_WIDTH-1], s1_data}
            + {bus.ADC_CAL_OFFSET[FP_WIDTH-1], bus.ADC_CAL_OFFSET};
    // Overflow when the extra sign bit disagrees with the result sign.
    add_sat = add_sum[FP_WIDTH] != add_sum[FP_WIDTH-1];
    if (add_sat) begin
      add_res = add_sum[FP_WIDTH] ? SAT_NEG : SAT_POS;
    end else begin
      add_res = add_sum[FP_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s2_data  <= '0;
      s2_flags <= '0;
    end else begin
      s2_flags.valid <= s1_flags.valid;
      s2_flags.sat   <= s1_flags.sat | add_sat;
      if (s1_flags.valid) begin
        s2_data <= add_res;
      end
    end
  end

  // ---------------- stage 3: * gain, output register ----------------
  logic [FP_WIDTH-1:0] mul3_res;
  logic                mul3_sat;

  fp_sat_mult #(.FP_WIDTH(FP_WIDTH), .INT_WIDTH(INT_WIDTH)) u_mul_gain (
    .a   (s2_data),
    .b   (bus.ADC_CAL_GAIN),
    .res (mul3_res),
    .sat (mul3_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus.VOLTAGE_OUT   <= '0;
      bus.VOLTAGE_VALID <= 1'b0;
      bus.VOLTAGE_SAT   <= 1'b0;
    end else begin
      bus.VOLTAGE_VALID <= s2_flags.valid;
      if (s2_flags.valid) begin
        bus.VOLTAGE_OUT <= mul3_res;
        bus.VOLTAGE_SAT <= s2_flags.sat | mul3_sat;
      end
    end
  end

endmodule

// File: tb/tb_adc_in.sv
// Directed bench for adc_in: each expected result (value, saturation flag,
// strobe cycle) is queued when its window-completing sample is driven; a
// negedge monitor pops and compares on every VOLTAGE_VALID.
module tb_adc_in;

  localparam int FP_W  = 64;
  localparam int ADC_W = 14;
  localparam int EW    = 1 + FP_W + 32;   // {sat, value, strobe cycle}

  localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
  localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NMAX = 64'h8000_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_in_if #(.FP_WIDTH(FP_W), .ADC_WIDTH(ADC_W)) bus ();

  adc_in dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.VOLTAGE_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe value %h want none (cycle %0d)",
                 bus.VOLTAGE_OUT, cyc);
      end else begin
        e = exp_q.pop_front();
        check("voltage_out", bus.VOLTAGE_OUT, e[95:32]);
        check("voltage_sat", 64'(bus.VOLTAGE_SAT), 64'(e[96]));
        check("strobe_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one sample; a window-completing sample queues its expected result,
  // due three cycles after the edge that samples it.
  task automatic sample(input logic [ADC_W-1:0] code, input bit expect_out,
                        input logic [63:0] ev, input bit es);
    @(negedge clk);
    bus.ADC_CODE_IN = code;
    bus.ADC_VALID   = 1'b1;
    if (expect_out) exp_q.push_back({es, ev, 32'(cyc + 3)});
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    bus.ADC_VALID = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.ADC_VALID = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out", bus.VOLTAGE_OUT, 64'h0);
    check("rst_valid", 64'(bus.VOLTAGE_VALID), 64'h0);
    check("rst_sat", 64'(bus.VOLTAGE_SAT), 64'h0);
    rst_n = 1'b1;
  endtask

  // Back-to-back vectors at gain 1.0, offset 0: code * -5 * 2^-12.
  logic [ADC_W-1:0] b2b_code[10] = '{14'h0000, 14'h0001, 14'h3FFF, 14'h0002, 14'h1000,
                                     14'h3000, 14'h1FFF, 14'h2000, 14'h0064, 14'h3F9C};
  logic [63:0]      b2b_exp[10]  = '{64'h0000_0000_0000_0000, 64'hFFFF_FFB0_0000_0000,
                                     64'h0000_0050_0000_0000, 64'hFFFF_FF60_0000_0000,
                                     64'hFFFB_0000_0000_0000, 64'h0005_0000_0000_0000,
                                     64'hFFF6_0050_0000_0000, 64'h000A_0000_0000_0000,
                                     64'hFFFF_E0C0_0000_0000, 64'h0000_1F40_0000_0000};

  // ---------------- stimulus ----------------
  initial begin
    bus.ADC_CODE_IN    = '0;
    bus.ADC_VALID      = 1'b0;
    bus.AVG_LOG2       = 4'd0;
    bus.ADC_CAL_GAIN   = ONE;
    bus.ADC_CAL_OFFSET = 64'h0;
    rst_n              = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", bus.VOLTAGE_OUT, 64'h0);
    check("reset_valid", 64'(bus.VOLTAGE_VALID), 64'h0);
    check("reset_sat", 64'(bus.VOLTAGE_SAT), 64'h0);
    rst_n = 1'b1;
    gap(2);

    // single samples, no averaging: -5.0 and +10.0
    sample(14'h1000, 1, 64'hFFFB_0000_0000_0000, 0);
    gap(5);
    sample(14'h2000, 1, 64'h000A_0000_0000_0000, 0);
    gap(5);

    // four-sample window on scattered cycles: mean 10
    bus.AVG_LOG2 = 4'd2;
    sample(14'd4, 0, 64'h0, 0);  gap(2);
    sample(14'd8, 0, 64'h0, 0);  gap(1);
    sample(14'd12, 0, 64'h0, 0); gap(3);
    sample(14'd16, 1, 64'hFFFF_FCE0_0000_0000, 0);
    gap(5);

    // exponent change mid-window drops the two 0x1000 samples: mean 16
    sample(14'h1000, 0, 64'h0, 0);
    sample(14'h1000, 0, 64'h0, 0);
    gap(1);
    bus.AVG_LOG2 = 4'd1;
    gap(1);
    sample(14'h0010, 0, 64'h0, 0);
    sample(14'h0010, 1, 64'hFFFF_FB00_0000_0000, 0);
    gap(5);

    // offset +2.0: -5 + 2 = -3
    bus.AVG_LOG2       = 4'd0;
    bus.ADC_CAL_OFFSET = 64'h0002_0000_0000_0000;
    sample(14'h1000, 1, 64'hFFFD_0000_0000_0000, 0);
    gap(5);

    // offset 32767.0 + 10.0 overflows the adder
    bus.ADC_CAL_OFFSET = 64'h7FFF_0000_0000_0000;
    sample(14'h2000, 1, PMAX, 1);
    gap(5);
    bus.ADC_CAL_OFFSET = 64'h0;

    // gain 32767.0: positive clamp, clean zero, negative clamp
    bus.ADC_CAL_GAIN = 64'h7FFF_0000_0000_0000;
    sample(14'h2000, 1, PMAX, 1);
    sample(14'h0000, 1, 64'h0, 0);
    sample(14'h1000, 1, NMAX, 1);
    gap(6);
    check("hold_out", bus.VOLTAGE_OUT, NMAX);
    check("hold_sat", 64'(bus.VOLTAGE_SAT), 64'h1);
    bus.ADC_CAL_GAIN = ONE;

    // reset while a result is in the pipeline: that result never appears
    sample(14'h1000, 0, 64'h0, 0);
    pulse_reset();
    gap(5);

    // reset mid-window, then a full window of 0x10: mean 16
    bus.AVG_LOG2 = 4'd3;
    gap(1);
    for (int i = 0; i < 5; i++) sample(14'h0010, 0, 64'h0, 0);
    pulse_reset();
    for (int i = 0; i < 7; i++) sample(14'h0010, 0, 64'h0, 0);
    sample(14'h0010, 1, 64'hFFFF_FB00_0000_0000, 0);
    gap(5);

    // exponent above the maximum clamps to 8 (256 samples of 0x1000)
    bus.AVG_LOG2 = 4'd15;
    gap(1);
    for (int i = 0; i < 255; i++) sample(14'h1000, 0, 64'h0, 0);
    sample(14'h1000, 1, 64'hFFFB_0000_0000_0000, 0);
    gap(5);

    // ten back-to-back samples, one strobe each, order kept
    bus.AVG_LOG2 = 4'd0;
    gap(1);
    for (int i = 0; i < 10; i++) sample(b2b_code[i], 1, b2b_exp[i], 0);
    gap(8);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results still pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_in.md
ADC_IN -- requirements
Module: adc_in

Interface
REQ-001 Parameter FP_WIDTH, default 64: width of the fixed-point voltage, gain and offset words (Q16.48).
REQ-002 Parameter ADC_WIDTH, default 14: ADC code width, two's complement.
REQ-003 Parameter INT_WIDTH, default 16: integer bits of the fixed-point format.
REQ-004 Parameter MAX_AVG_LOG2, default 8: largest supported averaging exponent.
REQ-005 CLK  input  1  sole clock; all logic on rising edge.
REQ-006 RST_N  input  1  reset; synchronous, active-low.
REQ-007 ADC_CODE_IN  input  ADC_WIDTH  raw ADC sample.
REQ-008 ADC_VALID  input  1  ADC_CODE_IN is sampled on this cycle.
REQ-009 AVG_LOG2  input  4  window length 2^AVG_LOG2 samples; values above MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
REQ-010 ADC_CAL_GAIN  input  FP_WIDTH  calibration gain, Q16.48 signed.
REQ-011 ADC_CAL_OFFSET  input  FP_WIDTH  calibration offset, Q16.48 signed.
REQ-012 VOLTAGE_OUT  output  FP_WIDTH  calibrated voltage, Q16.48 signed, registered.
REQ-013 VOLTAGE_VALID  output  1  one-cycle strobe, VOLTAGE_OUT is new.
REQ-014 VOLTAGE_SAT  output  1  registered with VOLTAGE_OUT; high when the result saturated.

Function
REQ-015 The block SHALL form the inverse of the DAC output path: VOLTAGE_OUT = ((avg_code * K) + ADC_CAL_OFFSET) * ADC_CAL_GAIN, where K = -20/16384 = -5*2^-12, exact in Q16.48.
REQ-016 Accumulator: sign-extended to ADC_WIDTH+MAX_AVG_LOG2 bits; each ADC_VALID adds ADC_CODE_IN; sample counter increments.
REQ-017 On the 2^AVG_LOG2-th accepted sample, the block SHALL compute avg_code = (accumulator including this sample) arithmetically shifted right by AVG_LOG2 (floor rounding), clear accumulator and counter, and launch the pipeline.
REQ-018 AVG_LOG2 = 0: every ADC_VALID launches the pipeline (no averaging).
REQ-019 AVG_LOG2 is latched at window start; a change mid-window SHALL discard the partial window and restart counting with the new value from the next ADC_VALID.
REQ-020 Pipeline: stage 1 avg_code*K; stage 2 +ADC_CAL_OFFSET; stage 3 *ADC_CAL_GAIN, select product bits [2*FP_WIDTH-1-INT_WIDTH : FP_WIDTH-INT_WIDTH].
REQ-021 Latency: VOLTAGE_VALID asserts exactly 3 cycles after the cycle the window-completing ADC_VALID is sampled; throughput one result per cycle.
REQ-022 Saturation: if discarded high product bits are not all equal to the selected sign bit, VOLTAGE_OUT SHALL be 0x7FFF_FFFF_FFFF_FFFF (positive) or 0x8000_0000_0000_0000 (negative) and VOLTAGE_SAT high; stage-2 addition saturates the same way.
REQ-023 ADC_CAL_GAIN/ADC_CAL_OFFSET are sampled at their stage; changes affect only results entering that stage afterwards.
REQ-024 VOLTAGE_OUT and VOLTAGE_SAT hold their value between strobes.

Reset
REQ-025 While RST_N low at a clock edge: accumulator, counter, pipeline valids, VOLTAGE_OUT = 0, VOLTAGE_VALID = 0, VOLTAGE_SAT = 0.
REQ-026 Reset mid-window or mid-pipeline SHALL discard all in-flight data; no VOLTAGE_VALID for pre-reset samples.

Structure
REQ-027 Constants K (Q16.48), the Q16.48 saturation limits and format widths SHALL live in the shared fixed-point package used by DAC_OUT.
REQ-028 One sub-module, fp_sat_mult (signed multiply, Q16.48 bit select, saturation flag), instantiated for stages 1 and 3.

Verification
REQ-029 AVG_LOG2=0, gain 0x0001_0000_0000_0000, offset 0, code 0x1000 -> VOLTAGE_OUT 0xFFFB_0000_0000_0000 (-5.0), VALID 3 cycles later, SAT 0.
REQ-030 Same setup, code 0x2000 (-8192) -> 0x000A_0000_0000_0000 (+10.0).
REQ-031 AVG_LOG2=2, codes 4,8,12,16 on non-consecutive cycles -> single strobe, VOLTAGE_OUT 0xFFFF_FCE0_0000_0000; no strobe after first three samples.
REQ-032 Gain 0x7FFF_0000_0000_0000, code 0x2000 -> VOLTAGE_OUT 0x7FFF_FFFF_FFFF_FFFF, SAT 1; next unsaturated result clears SAT.
REQ-033 AVG_LOG2=3, 5 samples, RST_N low one cycle, then 8 samples of 0x0010 -> exactly one strobe, value from the 8 post-reset samples only.
REQ-034 Back-to-back ADC_VALID with AVG_LOG2=0, 10 samples -> 10 consecutive strobes, order preserved.
